// File: rtl/mem_stage_ls.sv
// rtl/mem_stage_ls.sv - memory-access pipeline stage with byte/half/word load-store and MEM/WB register
module mem_stage_ls #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic              ex_reg_write,
  input  logic [RA_W-1:0]   ex_wb_addr,
  input  logic [DATA_W-1:0] ex_alu_z,
  input  logic [DATA_W-1:0] ex_rd_data,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RA_W-1:0]   wb_wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc,
  output logic [DATA_W-1:0] wb_exc_addr
);

  // first byte address past the end of the data memory
  localparam logic [DATA_W-1:0] LP_LIMIT = DATA_W'(DEPTH * 4);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [RA_W-1:0]   r_wb_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_exc;
  logic [DATA_W-1:0] r_wb_exc_addr;

  logic [ADDR_W-1:0] w_idx;
  logic              w_in_range;
  logic              w_misaligned;
  logic              w_act;
  logic              w_fault;
  logic              w_we;
  logic [DATA_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;

  assign w_idx        = ex_alu_z[ADDR_W+1:2];
  assign w_in_range   = ex_alu_z < LP_LIMIT;
  // size 1x is a word access (11 is treated as word)
  assign w_misaligned = ((ex_mem_size == 2'b01) & ex_alu_z[0]) |
                        (ex_mem_size[1] & (ex_alu_z[1:0] != 2'b00));
  assign w_act        = ex_valid & ~flush;
  assign w_fault      = w_act & (ex_mem_read | ex_mem_write) & (w_misaligned | ~w_in_range);
  assign w_we         = w_act & ex_mem_write & ~w_fault & ~stall;

  // combinational load path: pick the lane(s) and extend
  always_comb begin
    w_word = w_in_range ? r_mem[w_idx] : '0;
    case (ex_alu_z[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = ex_alu_z[1] ? w_word[31:16] : w_word[15:0];
    case (ex_mem_size)
      2'b00:   w_load = ex_mem_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                        : {{(DATA_W-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = ex_mem_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                        : {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  assign fwd_data = ex_mem_read ? w_load : ex_alu_z;

  // store lane enables and replicated store data
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = ex_rd_data;
    case (ex_mem_size)
      2'b00: begin
        w_be[ex_alu_z[1:0]] = 1'b1;
        w_wdata             = {4{ex_rd_data[7:0]}};
      end
      2'b01: begin
        w_be    = ex_alu_z[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_rd_data[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  // data memory: cleared by reset, byte-lane write otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // MEM/WB register: flush beats stall; wb_exc is always a single pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_wb_addr   <= '0;
      r_wb_data      <= '0;
      r_wb_exc       <= 1'b0;
      r_wb_exc_addr  <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_exc       <= 1'b0;
    end else if (stall) begin
      r_wb_exc       <= 1'b0;
    end else begin
      r_wb_valid     <= ex_valid;
      r_wb_reg_write <= ex_valid & ex_reg_write & ~w_fault;
      r_wb_wb_addr   <= ex_wb_addr;
      r_wb_data      <= fwd_data;
      r_wb_exc       <= w_fault;
      if (w_fault) r_wb_exc_addr <= ex_alu_z;
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_wb_addr   = r_wb_wb_addr;
  assign wb_data      = r_wb_data;
  assign wb_exc       = r_wb_exc;
  assign wb_exc_addr  = r_wb_exc_addr;

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb/tb_mem_stage_ls.sv - self-checking bench for mem_stage_ls against a byte-array model
module tb_mem_stage_ls;

  logic        clk, rst, stall, flush, ex_valid, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned, ex_reg_write;
  logic [4:0]  ex_wb_addr;
  logic [31:0] ex_alu_z, ex_rd_data;
  logic [31:0] fwd_data, wb_data, wb_exc_addr;
  logic        wb_valid, wb_reg_write, wb_exc;
  logic [4:0]  wb_wb_addr;

  int checks = 0;
  int failures = 0;

  mem_stage_ls dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_reg_write(ex_reg_write), .ex_wb_addr(ex_wb_addr),
    .ex_alu_z(ex_alu_z), .ex_rd_data(ex_rd_data), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wb_addr(wb_wb_addr),
    .wb_data(wb_data), .wb_exc(wb_exc), .wb_exc_addr(wb_exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: 1 KiB of little-endian bytes plus expected MEM/WB state
  logic [7:0]  mem_m [1024];
  logic [31:0] exp_fwd;
  bit          fwd_known;
  logic        exp_valid, exp_rw, exp_exc;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data, exp_exc_addr;
  bit          data_known;
  logic        n_valid, n_rw, n_exc;
  logic [4:0]  n_addr;
  logic [31:0] n_data, n_exc_addr;
  bit          n_known;
  bit          p_we;
  logic [31:0] p_alu, p_dat;
  logic [1:0]  p_sz;

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic uns);
    int n;
    logic [31:0] v;
    if (a >= 32'd1024) return 32'd0;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++)
      if (int'(a) + i < 1024) v |= 32'(mem_m[int'(a) + i]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    exp_valid = 0; exp_rw = 0; exp_exc = 0; exp_addr = 0;
    exp_data = 0; exp_exc_addr = 0; data_known = 1; p_we = 0;
  endtask

  task automatic drive(input logic v, rd, wr, input logic [1:0] sz, input logic uns, rw,
                       input logic [4:0] wa, input logic [31:0] alu, dat, input logic st, fl);
    bit act, big, mis, flt;
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_reg_write = rw; ex_wb_addr = wa; ex_alu_z = alu;
    ex_rd_data = dat; stall = st; flush = fl;
    act = v && !fl;
    big = alu >= 32'd1024;
    mis = (sz == 2'd1 && alu[0]) || (sz >= 2'd2 && alu[1:0] != 2'd0);
    flt = act && (rd || wr) && (mis || big);
    exp_fwd = rd ? model_load(alu, sz, uns) : alu;
    fwd_known = !rd || big || !mis;
    p_we = act && wr && !flt && !st;
    p_alu = alu; p_dat = dat; p_sz = sz;
    n_valid = exp_valid; n_rw = exp_rw; n_addr = exp_addr; n_data = exp_data;
    n_known = data_known; n_exc = 0; n_exc_addr = exp_exc_addr;
    if (fl) begin
      n_valid = 0; n_rw = 0;
    end else if (!st) begin
      n_valid = v; n_rw = v && rw && !flt; n_addr = wa; n_data = exp_fwd;
      n_known = fwd_known; n_exc = flt;
      if (flt) n_exc_addr = alu;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_we)
      for (int i = 0; i < nbytes(p_sz); i++) mem_m[int'(p_alu) + i] = p_dat[8*i +: 8];
    p_we = 0;
    exp_valid = n_valid; exp_rw = n_rw; exp_addr = n_addr; exp_data = n_data;
    data_known = n_known; exp_exc = n_exc; exp_exc_addr = n_exc_addr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'd2, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 0, 2'd0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    model_reset();
    #12;
    checks += 6;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", wb_valid); end
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b want=0", wb_reg_write); end
    if (wb_wb_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", wb_wb_addr); end
    if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h want=0", wb_data); end
    if (wb_exc !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b want=0", wb_exc); end
    if (wb_exc_addr !== 32'd0) begin failures++; $display("FAIL reset_exc_addr got=%h want=0", wb_exc_addr); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    drive(1, 0, 1, 2'd2, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 0, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 1, 5'd7, 32'h10, 32'd0, 0, 0);
    #1;
    checks++;
    if (fwd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL word_fwd got=%h want=deadbeef", fwd_data); end
    tick();
    checks += 4;
    if (wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL word_data got=%h want=deadbeef", wb_data); end
    if (wb_wb_addr !== 5'd7) begin failures++; $display("FAIL word_addr got=%0d want=7", wb_wb_addr); end
    if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL word_rw got=%b want=1", wb_reg_write); end
    if (wb_exc !== 1'b0) begin failures++; $display("FAIL word_exc got=%b want=0", wb_exc); end
  endtask

  task automatic test_extension();
    logic [31:0] want [4];
    logic [31:0] addr [4];
    logic [1:0]  sz [4];
    logic        uns [4];
    want = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    addr = '{32'h13, 32'h13, 32'h12, 32'h10};
    sz   = '{2'd0, 2'd0, 2'd1, 2'd1};
    uns  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, sz[i], uns[i], 1, 5'd3, addr[i], 32'd0, 0, 0); tick();
      checks++;
      if (wb_data !== want[i]) begin
        failures++; $display("FAIL ext_%0d got=%h want=%h", i, wb_data, want[i]);
      end
    end
  endtask

  task automatic test_partial();
    drive(1, 0, 1, 2'd0, 0, 0, 5'd0, 32'h11, 32'hAAAAAA55, 0, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 1, 5'd1, 32'h10, 32'd0, 0, 0); tick();
    checks++;
    if (wb_data !== 32'hDEAD55EF) begin failures++; $display("FAIL partial got=%h want=dead55ef", wb_data); end
  endtask

  task automatic test_misalign();
    drive(1, 0, 1, 2'd1, 0, 1, 5'd2, 32'h11, 32'h00009999, 0, 0); tick();
    checks += 3;
    if (wb_exc !== 1'b1) begin failures++; $display("FAIL mis_exc got=%b want=1", wb_exc); end
    if (wb_exc_addr !== 32'h11) begin failures++; $display("FAIL mis_exc_addr got=%h want=11", wb_exc_addr); end
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL mis_rw got=%b want=0", wb_reg_write); end
    drive(1, 1, 0, 2'd2, 0, 1, 5'd2, 32'h10, 32'd0, 0, 0); tick();
    checks += 2;
    if (wb_exc !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b want=0", wb_exc); end
    if (wb_data !== 32'hDEAD55EF) begin failures++; $display("FAIL mis_unchanged got=%h want=dead55ef", wb_data); end
    drive(1, 1, 0, 2'd2, 0, 1, 5'd4, 32'h402, 32'd0, 0, 0); tick();
    checks += 3;
    if (wb_exc !== 1'b1) begin failures++; $display("FAIL range_exc got=%b want=1", wb_exc); end
    if (wb_exc_addr !== 32'h402) begin failures++; $display("FAIL range_exc_addr got=%h want=402", wb_exc_addr); end
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL range_rw got=%b want=0", wb_reg_write); end
    idle();
    checks++;
    if (wb_exc_addr !== 32'h402) begin failures++; $display("FAIL exc_addr_hold got=%h want=402", wb_exc_addr); end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 0, 2'd2, 0, 1, 5'd9, 32'h10, 32'd0, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 1, 2'd2, 0, 0, 5'd1, 32'h20, 32'h1234, 1, 0); tick();
      checks += 4;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_%0d got=%b want=1", c, wb_valid); end
      if (wb_wb_addr !== 5'd9) begin failures++; $display("FAIL stall_addr_%0d got=%0d want=9", c, wb_wb_addr); end
      if (wb_data !== 32'hDEAD55EF) begin failures++; $display("FAIL stall_data_%0d got=%h want=dead55ef", c, wb_data); end
      if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL stall_rw_%0d got=%b want=1", c, wb_reg_write); end
    end
    drive(1, 1, 0, 2'd2, 0, 1, 5'd1, 32'h20, 32'd0, 1, 0);
    #1;
    checks++;
    if (fwd_data !== 32'd0) begin failures++; $display("FAIL stall_nowrite got=%h want=0", fwd_data); end
    tick();
    drive(1, 0, 1, 2'd2, 0, 0, 5'd1, 32'h20, 32'h1234, 0, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 1, 5'd6, 32'h20, 32'd0, 1, 1); tick();
    checks += 2;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", wb_valid); end
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL flush_rw got=%b want=0", wb_reg_write); end
    drive(1, 1, 0, 2'd2, 0, 1, 5'd6, 32'h20, 32'd0, 0, 0); tick();
    checks++;
    if (wb_data !== 32'h1234) begin failures++; $display("FAIL stall_written got=%h want=1234", wb_data); end
  endtask

  task automatic test_read_write_same();
    drive(1, 1, 1, 2'd2, 0, 1, 5'd5, 32'h20, 32'h0BADF00D, 0, 0);
    #1;
    checks++;
    if (fwd_data !== 32'h1234) begin failures++; $display("FAIL rw_fwd got=%h want=1234", fwd_data); end
    tick();
    checks++;
    if (wb_data !== 32'h1234) begin failures++; $display("FAIL rw_old got=%h want=1234", wb_data); end
    drive(1, 1, 0, 2'd2, 0, 1, 5'd5, 32'h20, 32'd0, 0, 0); tick();
    checks++;
    if (wb_data !== 32'h0BADF00D) begin failures++; $display("FAIL rw_new got=%h want=0badf00d", wb_data); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 1, 2'd2, 0, 1, 5'd3, 32'h20, 32'hCAFEF00D, 0, 0);
    #2;
    rst = 1;
    #1;
    model_reset();
    checks += 6;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", wb_valid); end
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL arst_rw got=%b want=0", wb_reg_write); end
    if (wb_wb_addr !== 5'd0) begin failures++; $display("FAIL arst_addr got=%0d want=0", wb_wb_addr); end
    if (wb_data !== 32'd0) begin failures++; $display("FAIL arst_data got=%h want=0", wb_data); end
    if (wb_exc !== 1'b0) begin failures++; $display("FAIL arst_exc got=%b want=0", wb_exc); end
    if (wb_exc_addr !== 32'd0) begin failures++; $display("FAIL arst_exc_addr got=%h want=0", wb_exc_addr); end
    #1;
    rst = 0;
    drive(1, 1, 0, 2'd2, 0, 1, 5'd3, 32'h20, 32'd0, 0, 0);
    #1;
    checks++;
    if (fwd_data !== 32'd0) begin failures++; $display("FAIL arst_fwd got=%h want=0", fwd_data); end
    tick();
    checks++;
    if (wb_data !== 32'd0) begin failures++; $display("FAIL arst_mem got=%h want=0", wb_data); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(1024, 4200));
      drive($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom), a, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      #1;
      if (fwd_known) begin
        checks++;
        if (fwd_data !== exp_fwd) begin failures++; $display("FAIL rnd_fwd_%0d got=%h want=%h", n, fwd_data, exp_fwd); end
      end
      tick();
      checks += 5;
      if (wb_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid_%0d got=%b want=%b", n, wb_valid, exp_valid); end
      if (wb_reg_write !== exp_rw) begin failures++; $display("FAIL rnd_rw_%0d got=%b want=%b", n, wb_reg_write, exp_rw); end
      if (wb_wb_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr_%0d got=%0d want=%0d", n, wb_wb_addr, exp_addr); end
      if (wb_exc !== exp_exc) begin failures++; $display("FAIL rnd_exc_%0d got=%b want=%b", n, wb_exc, exp_exc); end
      if (wb_exc_addr !== exp_exc_addr) begin failures++; $display("FAIL rnd_exc_addr_%0d got=%h want=%h", n, wb_exc_addr, exp_exc_addr); end
      if (data_known) begin
        checks++;
        if (wb_data !== exp_data) begin failures++; $display("FAIL rnd_data_%0d got=%h want=%h", n, wb_data, exp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_partial();
    test_misalign();
    test_stall_flush();
    test_read_write_same();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
